mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- AW, 16, address width.
- DW, 16, data width.
- TMO, 15, maximum BUSY cycles before abort (range 1..255).

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_rd  in  1  control-path memory read request.
- cpu_wr  in  1  control-path memory write request.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data.
- cpu_ack  out  1  CPU access complete.
- cpu_stall  out  1  hold control FSM state.
- ld_req  in  1  loader/debug request.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_rdata  out  DW  loader read data.
- ld_ack  out  1  loader access complete.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completes access this cycle.
- tmo_err  out  1  sticky timeout flag.
- err_clr  in  1  clears tmo_err.

REQ-003 Reset SHALL be synchronous and active-high on port reset, sampled on posedge clk.

Function
REQ-004 FSM states SHALL be IDLE, CPU_BUSY and LD_BUSY.
REQ-005 A CPU request SHALL be cpu_rd|cpu_wr; a loader request SHALL be ld_req. Requesters hold address, data and request until their ack.
REQ-006 If cpu_rd and cpu_wr are both high, the access SHALL be a write.
REQ-007 In IDLE, a requester whose ack is high in the current cycle SHALL NOT be eligible for grant.
REQ-008 In IDLE with one eligible requester, the FSM SHALL go to that requester's BUSY state on the next edge.
REQ-009 In IDLE with both requesters eligible, the FSM SHALL grant the requester not granted last (last_grant register; round-robin).
REQ-010 On grant, mem_addr, mem_wdata and mem_we SHALL be registered from the granted requester, and mem_en SHALL be 1 throughout BUSY.
REQ-011 Memory outputs SHALL stay stable throughout BUSY.
REQ-012 mem_en SHALL be 0 in IDLE.
REQ-013 In BUSY with mem_ready=1, the FSM SHALL return to IDLE on the next edge.
REQ-014 The granted requester's ack SHALL be 1 for exactly the following cycle.
REQ-015 On a read completion, mem_rdata SHALL be captured into that requester's rdata; rdata otherwise holds its value.
REQ-016 Minimum latency SHALL be: request seen in IDLE at cycle 0 -> mem_en at cycle 1 -> ack at cycle 2 if mem_ready at cycle 1.
REQ-017 The other requester MAY be granted in the ack cycle (back-to-back, 2 cycles per access).
REQ-018 A BUSY cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-019 When the counter reaches TMO without mem_ready: abort to IDLE, pulse the granted requester's ack, load rdata with all-ones on reads, and set tmo_err.
REQ-020 mem_ready in the same cycle the counter reaches TMO SHALL count as normal completion; tmo_err is not set.
REQ-021 tmo_err SHALL clear on err_clr=1; a simultaneous set SHALL win over clear.
REQ-022 cpu_stall SHALL be combinational (cpu_rd|cpu_wr)&~cpu_ack.
REQ-023 A request dropped during BUSY SHALL NOT abort the memory access; completion and ack still occur.

Reset
REQ-024 While reset=1, state SHALL be IDLE and mem_en, mem_we, cpu_ack, ld_ack and tmo_err SHALL be 0.
REQ-025 While reset=1, mem_addr, mem_wdata, cpu_rdata, ld_rdata and the counter SHALL be 0, and last_grant SHALL be loader, so the CPU wins the first tie.
REQ-026 Reset asserted during BUSY SHALL abandon the access: mem_en=0 on the next cycle, no ack issued.

Verification
REQ-027 CPU read: cpu_rd=1, cpu_addr=0x0010, mem_ready=1 at first mem_en cycle, mem_rdata=0xBEEF -> mem_en at cycle 1, cpu_ack at cycle 2, cpu_rdata=0xBEEF, cpu_stall 1 at cycles 0-1 and 0 at cycle 2.
REQ-028 Tie after reset: cpu_wr and ld_req both high continuously, mem_ready tied 1 -> grants alternate CPU, LD, CPU, LD; acks at cycles 2, 4, 6, 8.
REQ-029 Wait states: ld_req read, mem_ready low 3 cycles then high, mem_rdata=0x1234 -> mem_en high 4 cycles, mem_addr stable, ld_ack one cycle, ld_rdata=0x1234.
REQ-030 Timeout: TMO=15, cpu_rd, mem_ready held 0 -> abort after 15 BUSY cycles, cpu_ack pulse, cpu_rdata=0xFFFF, tmo_err=1; err_clr=1 -> tmo_err=0 next cycle.
REQ-031 Reset mid-access: reset=1 in second BUSY cycle -> next cycle mem_en=0, state IDLE, no ack; after release, pending cpu_rd regranted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between a CPU and a loader, with a busy-cycle timeout.
module mem_port_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          tmo_err,
    input  logic          err_clr
);
    typedef enum logic [1:0] {IDLE, CPU_BUSY, LD_BUSY} state_t;
    state_t state, state_nx;
    logic last_ld;
    logic [7:0] cnt;
    logic cpu_req, cpu_el, ld_el, grant_cpu, grant_ld, busy, tmo_hit, done;
    assign cpu_req   = cpu_rd | cpu_wr;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_el    = cpu_req & ~cpu_ack;
    assign ld_el     = ld_req & ~ld_ack;
    assign busy      = state != IDLE;
    assign mem_en    = busy;
    assign grant_cpu = !busy && cpu_el && (!ld_el || last_ld);
    assign grant_ld  = !busy && ld_el && !grant_cpu;
    // The TMO-th busy cycle without ready aborts; ready on that cycle still completes normally.
    assign tmo_hit   = busy && !mem_ready && cnt == 8'(TMO - 1);
    assign done      = busy && (mem_ready || tmo_hit);
    always_comb begin
        state_nx = state;
        state_nx = grant_cpu ? CPU_BUSY : grant_ld ? LD_BUSY : done ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_ld   <= 1'b1;
            cnt       <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tmo_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            cpu_ack <= done && state == CPU_BUSY;
            ld_ack  <= done && state == LD_BUSY;
            tmo_err <= tmo_hit | (tmo_err & ~err_clr);
            if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_we    <= cpu_wr;
                last_ld   <= 1'b0;
                cnt       <= '0;
            end else if (grant_ld) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
                mem_we    <= ld_we;
                last_ld   <= 1'b1;
                cnt       <= '0;
            end else if (busy && !mem_ready && !tmo_hit)
                cnt <= cnt + 8'd1;
            if (done && !mem_we && state == CPU_BUSY)
                cpu_rdata <= tmo_hit ? '1 : mem_rdata;
            if (done && !mem_we && state == LD_BUSY)
                ld_rdata <= tmo_hit ? '1 : mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random two-requester traffic checked against a transaction-level model of the shared port.
module tb_mem_port_arbiter;
    localparam int AW = 16, DW = 16, TMO = 15;
    logic clk = 0, reset = 1;
    logic cpu_rd = 0, cpu_wr = 0, ld_req = 0, ld_we = 0, mem_ready = 0, err_clr = 0;
    logic [AW-1:0] cpu_addr = 0, ld_addr = 0;
    logic [DW-1:0] cpu_wdata = 0, ld_wdata = 0, mem_rdata = 0;
    logic [DW-1:0] cpu_rdata, ld_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, tmo_err;
    int vectors = 0, errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .tmo_err(tmo_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Model: who owns the port (0 none, 1 cpu, 2 loader), how many busy cycles it has used, and the transaction latched at grant.
    int owner = 0, used = 0, last = 2;
    logic e_cack = 0, e_lack = 0, e_err = 0, e_we = 0;
    logic [DW-1:0] e_crd = 0, e_lrd = 0, e_wdata = 0;
    logic [AW-1:0] e_addr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic cw, lw, abort;
        if (reset) begin
            owner = 0; used = 0; last = 2;
            e_cack = 0; e_lack = 0; e_err = 0; e_we = 0;
            e_crd = 0; e_lrd = 0; e_wdata = 0; e_addr = 0;
            return;
        end
        cw = (cpu_rd | cpu_wr) && !e_cack;
        lw = ld_req && !e_lack;
        e_cack = 0; e_lack = 0; abort = 0;
        if (owner != 0) begin
            used++;
            if (mem_ready || used == TMO) begin
                abort = !mem_ready;
                if (owner == 1) e_cack = 1; else e_lack = 1;
                if (!e_we && owner == 1) e_crd = abort ? '1 : mem_rdata;
                if (!e_we && owner == 2) e_lrd = abort ? '1 : mem_rdata;
                owner = 0;
            end
        end else if (cw || lw) begin
            owner = (cw && lw) ? (last == 1 ? 2 : 1) : (cw ? 1 : 2);
            last = owner; used = 0;
            e_addr  = owner == 1 ? cpu_addr : ld_addr;
            e_wdata = owner == 1 ? cpu_wdata : ld_wdata;
            e_we    = owner == 1 ? cpu_wr : ld_we;
        end
        e_err = abort ? 1'b1 : (err_clr ? 1'b0 : e_err);
    endtask

    initial begin
        int mode;
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            chk("mem_en", mem_en, owner != 0);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("cpu_ack", cpu_ack, e_cack);
            chk("ld_ack", ld_ack, e_lack);
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("ld_rdata", ld_rdata, e_lrd);
            chk("tmo_err", tmo_err, e_err);
            mode = c / 600;
            reset = c < 2 || $urandom_range(0, 149) == 0;
            if (e_cack) begin
                cpu_rd = 0; cpu_wr = 0;
            end else if (!(cpu_rd | cpu_wr) && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin cpu_rd = 1; cpu_wr = 0; end
                    1: begin cpu_rd = 0; cpu_wr = 1; end
                    default: begin cpu_rd = 1; cpu_wr = 1; end
                endcase
                cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            if (e_lack) ld_req = 0;
            else if (!ld_req && $urandom_range(0, 1) == 0) begin
                ld_req = 1; ld_we = 1'($urandom); ld_addr = AW'($urandom); ld_wdata = DW'($urandom);
            end
            err_clr = $urandom_range(0, 7) == 0;
            mem_rdata = DW'($urandom);
            case (mode)
                0: mem_ready = $urandom_range(0, 9) < 6;
                1: mem_ready = 1;
                2: mem_ready = $urandom_range(0, 19) == 0;
                default: mem_ready = owner != 0 && used == TMO - 1;
            endcase
            #1;
            chk("cpu_stall", cpu_stall, (cpu_rd | cpu_wr) & ~e_cack);
            @(posedge clk);
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
